// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard controller: default register
// address width, forwarding-select encodings and tracking-entry flag widths.
package pipeline_pkg;

  localparam int RF_ADDR_WIDTH_DEFAULT = 5;

  // Flag bits carried by each tracking entry beside its register fields.
  localparam int E_FLAG_BITS = 3;  // regwrite, memtoreg, md
  localparam int M_FLAG_BITS = 2;  // regwrite, memtoreg
  localparam int W_FLAG_BITS = 1;  // regwrite

  // Execute-stage operand source select.
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  // Memory stage holds the younger result, so it wins over writeback.
  function automatic fwd_sel_e fwd_pick(input logic hit_mem, input logic hit_wb);
    if (hit_mem) return FWD_MEM;
    if (hit_wb)  return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Counts the extra Execute cycles of a multi-cycle mul/div op. Loaded with
// MD_LATENCY-1 when the op enters Execute, then counts down to zero; busy
// is high while the count is non-zero. MD_LATENCY=1 never raises busy.
module md_busy_counter #(
  parameter int MD_LATENCY = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic busy
);

  localparam int CW = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(MD_LATENCY - 1);

  logic [CW-1:0] count;

  // Countdown register: load on op entry, otherwise decrement toward zero.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage MIPS-style pipeline. Tracks the register
// usage of the E/M/W stages internally and produces stall, flush and
// forwarding controls, including stalls for a multi-cycle mul/div in Execute.
// Optional feature macro: HAZARD_PERF_CNT_EN (saturating stall-cycle counter
// on o_StallCount; tied to zero when undefined).
module pipeline_hazard_ctrl
  import pipeline_pkg::*;
#(
  parameter int RF_ADDR_WIDTH = RF_ADDR_WIDTH_DEFAULT,
  parameter int MD_LATENCY    = 4,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic [RF_ADDR_WIDTH-1:0] i_RsD,
  input  logic [RF_ADDR_WIDTH-1:0] i_RtD,
  input  logic [RF_ADDR_WIDTH-1:0] i_WriteRegD,
  input  logic                     i_RegWriteD,
  input  logic                     i_MemtoRegD,
  input  logic                     i_BranchD,
  input  logic                     i_MdStartD,
  output logic                     o_StallF,
  output logic                     o_StallD,
  output logic                     o_FlushE,
  output logic                     o_ForwardAD,
  output logic                     o_ForwardBD,
  output logic [1:0]               o_ForwardAE,
  output logic [1:0]               o_ForwardBE,
  output logic                     o_MdBusy,
  output logic [CNT_WIDTH-1:0]     o_StallCount
);

  typedef logic [RF_ADDR_WIDTH-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t rs;
    reg_addr_t rt;
    reg_addr_t dst;
    logic      regwrite;
    logic      memtoreg;
    logic      md;
  } e_entry_t;

  typedef struct packed {
    reg_addr_t dst;
    logic      regwrite;
    logic      memtoreg;
  } m_entry_t;

  typedef struct packed {
    reg_addr_t dst;
    logic      regwrite;
  } w_entry_t;

  // Register 0 is hard-wired, so a write to it never creates a dependency.
  function automatic logic reg_hit(input reg_addr_t dst, input reg_addr_t src);
    return (dst != '0) && (dst == src);
  endfunction

  e_entry_t e_q;
  m_entry_t m_q;
  w_entry_t w_q;
  e_entry_t dec_entry;

  logic lw_stall;
  logic br_stall;
  logic md_stall;
  logic md_busy;
  logic stall;
  logic flush_e;
  logic md_load;

  assign dec_entry = '{rs:       i_RsD,
                       rt:       i_RtD,
                       dst:      i_WriteRegD,
                       regwrite: i_RegWriteD,
                       memtoreg: i_MemtoRegD,
                       md:       i_MdStartD};

  // Stall and flush decisions from the tracked stages and the decode operands.
  // NOTE: every signal driven here gets a default first, so no path through
  // the block can leave one unassigned and infer a latch.
  always_comb begin
    lw_stall = 1'b0;
    br_stall = 1'b0;
    md_stall = 1'b0;

    lw_stall = e_q.regwrite && e_q.memtoreg &&
               (reg_hit(e_q.dst, i_RsD) || reg_hit(e_q.dst, i_RtD));

    br_stall = i_BranchD &&
               ((e_q.regwrite && (reg_hit(e_q.dst, i_RsD) || reg_hit(e_q.dst, i_RtD))) ||
                (m_q.memtoreg && (reg_hit(m_q.dst, i_RsD) || reg_hit(m_q.dst, i_RtD))));

    // The counter is only ever non-zero while the mul/div sits in Execute.
    md_stall = md_busy && e_q.md;
  end

  assign stall    = lw_stall | br_stall | md_stall;
  assign flush_e  = (lw_stall | br_stall) & ~md_stall;
  assign md_load  = i_MdStartD & ~md_stall & ~flush_e;

  assign o_StallF = stall;
  assign o_StallD = stall;
  assign o_FlushE = flush_e;
  assign o_MdBusy = md_busy;

  // Forwarding selects for Execute operands and the Decode branch compare.
  always_comb begin
    o_ForwardAE = FWD_RF;
    o_ForwardBE = FWD_RF;
    o_ForwardAD = 1'b0;
    o_ForwardBD = 1'b0;

    o_ForwardAE = fwd_pick(m_q.regwrite && reg_hit(m_q.dst, e_q.rs),
                           w_q.regwrite && reg_hit(w_q.dst, e_q.rs));
    o_ForwardBE = fwd_pick(m_q.regwrite && reg_hit(m_q.dst, e_q.rt),
                           w_q.regwrite && reg_hit(w_q.dst, e_q.rt));
    o_ForwardAD = m_q.regwrite && reg_hit(m_q.dst, i_RsD);
    o_ForwardBD = m_q.regwrite && reg_hit(m_q.dst, i_RtD);
  end

  // Stage tracking: W follows M; a mul/div holds E and bubbles M; a
  // load-use or branch hazard bubbles E; otherwise everything advances.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      w_q <= '{dst: m_q.dst, regwrite: m_q.regwrite};
      if (md_stall) begin
        m_q <= '0;
      end else begin
        m_q <= '{dst: e_q.dst, regwrite: e_q.regwrite, memtoreg: e_q.memtoreg};
        if (flush_e) begin
          e_q <= '0;
        end else begin
          e_q <= dec_entry;
        end
      end
    end
  end

  md_busy_counter #(
    .MD_LATENCY(MD_LATENCY)
  ) u_md_busy_counter (
    .clk  (i_CLK),
    .rst_n(i_RST),
    .load (md_load),
    .busy (md_busy)
  );

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_count;

  // Saturating count of cycles in which the front end is held.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      stall_count <= '0;
    end else if (stall && !(&stall_count)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

  assign o_StallCount = stall_count;
`else
  assign o_StallCount = '0;
`endif

endmodule
